// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: in-order pipeline writeback vs. buffered multi-cycle results,
// plus a per-register busy scoreboard. Define RF_WSCHED_STARVE_GUARD_EN to enable the FIFO starvation guard.
module rf_write_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        pipe_we_i,
  input  logic [4:0]                  pipe_dst_i,
  input  logic [31:0]                 pipe_data_i,
  output logic                        pipe_stall_o,
  input  logic                        mcu_issue_i,
  input  logic [4:0]                  mcu_issue_dst_i,
  output logic                        mcu_issue_block_o,
  input  logic                        mcu_valid_i,
  output logic                        mcu_ready_o,
  input  logic [4:0]                  mcu_dst_i,
  input  logic [31:0]                 mcu_data_i,
  input  logic [4:0]                  rd1_sel_i,
  input  logic [4:0]                  rd2_sel_i,
  output logic                        hazard_o,
  output logic                        rf_we_o,
  output logic [4:0]                  rf_dst_o,
  output logic [31:0]                 rf_data_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } entry_t;

  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        busy;

  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               grant_pipe;
  logic               grant_fifo;
  entry_t             head;
  logic [31:0]        set_mask;
  logic [31:0]        clr_mask;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign head         = fifo_mem[rd_ptr];
  assign mcu_ready_o  = !rst_i && !fifo_full;
  assign push         = mcu_valid_i && mcu_ready_o;
  assign fifo_count_o = count;

`ifdef RF_WSCHED_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  // A head that has waited STARVE_LIMIT cycles steals the port from a valid pipeline write.
  assign pipe_stall_o = !rst_i && !fifo_empty && pipe_we_i &&
                        (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (fifo_empty || grant_fifo) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
`else
  assign pipe_stall_o = 1'b0;
`endif

  // Fixed-priority grant of the single write port.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    if (rst_i) begin
      grant_pipe = 1'b0;
    end else if (pipe_stall_o) begin
      grant_fifo = 1'b1;
    end else if (pipe_we_i && (pipe_dst_i != 5'd0)) begin
      grant_pipe = 1'b1;
    end else if (!fifo_empty) begin
      grant_fifo = 1'b1;
    end
  end

  always_comb begin
    rf_we_o   = 1'b0;
    rf_dst_o  = 5'd0;
    rf_data_o = 32'd0;
    if (grant_pipe) begin
      rf_we_o   = 1'b1;
      rf_dst_o  = pipe_dst_i;
      rf_data_o = pipe_data_i;
    end else if (grant_fifo) begin
      // Entries aimed at x0 are still popped, just never written.
      rf_we_o   = (head.dst != 5'd0);
      rf_dst_o  = head.dst;
      rf_data_o = head.data;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by count/pointers, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{dst: mcu_dst_i, data: mcu_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (grant_fifo) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, grant_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard: a same-cycle issue re-marks a register whose older result is retiring.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (mcu_issue_i && (mcu_issue_dst_i != 5'd0)) begin
      set_mask = 32'd1 << mcu_issue_dst_i;
    end
    if (grant_fifo) begin
      clr_mask = 32'd1 << head.dst;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= 32'd0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  assign hazard_o          = busy[rd1_sel_i] | busy[rd2_sel_i];
  assign mcu_issue_block_o = busy[mcu_issue_dst_i];

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Schedules the single register-file write port between two writeback sources.
  - In-order pipeline writeback: fixed priority, no handshake.
  - Multi-cycle unit (divider/load) results: valid/ready handshake, buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding multi-cycle results, so decode can stall readers.
- Sits between WB/multi-cycle units and the rf write port, next to decode.

Parameters:
- FIFO_DEPTH, 4, multi-cycle result buffer entries (power of 2, >=2)
- STARVE_LIMIT, 3, cycles a non-empty FIFO head may wait before forcing a pipeline stall (only with guard enabled)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- pipe_we_i  in  1  pipeline writeback request
- pipe_dst_i  in  5  pipeline destination register
- pipe_data_i  in  32  pipeline write data
- pipe_stall_o  out  1  freeze pipeline writeback this cycle; upstream holds pipe_* stable
- mcu_issue_i  in  1  multi-cycle op issued this cycle
- mcu_issue_dst_i  in  5  destination of the issued op
- mcu_issue_block_o  out  1  busy[mcu_issue_dst_i]; issuer must not issue while high
- mcu_valid_i  in  1  multi-cycle result valid
- mcu_ready_o  out  1  FIFO can accept a result
- mcu_dst_i  in  5  result destination
- mcu_data_i  in  32  result data
- rd1_sel_i, rd2_sel_i  in  5 each  decode read selects
- hazard_o  out  1  busy[rd1_sel_i] or busy[rd2_sel_i]
- rf_we_o  out  1  to rf write_enable_i
- rf_dst_o  out  5  to rf reg_write_dst_i
- rf_data_o  out  32  to rf write_data_i
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_i high at posedge):
  - FIFO emptied, count 0; busy[31:0]=0; starve counter 0.
  - While rst_i is high: rf_we_o=0, pipe_stall_o=0, mcu_ready_o=0.
  - Reset mid-operation discards buffered results and clears all busy bits.
- Push: mcu_valid_i && mcu_ready_o at posedge writes {dst,data} to the tail.
  - mcu_ready_o = !rst_i && (count != FIFO_DEPTH).
  - Ready depends on registered count only; no same-cycle pop-through when full.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.
- Write port mux is combinational, evaluated each cycle:
  1. If pipe_stall_o: grant FIFO head.
  2. Else if pipe_we_i && pipe_dst_i!=0: grant pipeline; rf_* = pipe_*.
  3. Else if FIFO non-empty: grant FIFO head; pop at posedge.
  4. Else rf_we_o=0. rf_dst_o/rf_data_o are don't-care, but driven 0.
- Pipeline path latency 0.
- FIFO path latency is at least 1 cycle; there is no bypass from mcu_* into the write port.
- Register 0:
  - Pipeline writes to 0 never assert rf_we_o.
  - FIFO entries with dst 0 are popped with rf_we_o=0.
  - Issue to 0 never sets busy.
- Scoreboard:
  - busy[d] is set at posedge when mcu_issue_i with dst d.
  - busy[d] is cleared at posedge when a FIFO entry with dst d is granted.
  - Set and clear of the same register in the same cycle: set wins.
  - hazard_o and mcu_issue_block_o are combinational from the registered busy vector.
- Pipeline write to a busy register is illegal (decode stalls on hazard_o); the bench flags it as an error.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and its head is not granted.
  - Resets to 0 on FIFO grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.

Optional Feature:
- Macro: RF_WSCHED_STARVE_GUARD_EN.
- Defined: pipe_stall_o = (starve counter == STARVE_LIMIT) && FIFO non-empty && pipe_we_i.
  - The FIFO head takes the port that cycle.
  - The pipeline write is deferred one cycle.
  - The counter resets.
- Not defined: pipe_stall_o tied 0 and the counter is removed; the FIFO drains only in cycles with no valid pipeline write.

Test Plan:
- Reset, then idle: rf_we_o=0, mcu_ready_o=1, fifo_count_o=0, hazard_o=0.
- Pipeline write only (pipe_we_i=1, dst=5, data=0xDEADBEEF): same cycle rf_we_o=1, rf_dst_o=5, rf_data_o=0xDEADBEEF.
- Issue dst=7, rd1_sel_i=7 -> hazard_o=1 next cycle.
  - Result (7, 0x12345678) pushed while pipeline idle -> written the following cycle.
  - hazard_o=0 the cycle after that.
- Pipeline writes every cycle to dst 1..9 while 4 results are pushed:
  - mcu_ready_o drops at count 4.
  - Without the macro: no FIFO write until pipe_we_i drops.
  - With the macro: pipe_stall_o pulses after 3 waiting cycles, a FIFO entry is written, and the held pipeline write completes the next cycle.
- Issue dst=3 and FIFO grant of dst=3 in the same cycle -> busy[3] stays 1.
  - Push of dst=0 -> popped with rf_we_o=0.
- Assert rst_i with FIFO count 3 and busy[4]=1 -> the next cycle count 0, busy all 0, rf_we_o=0; none of the buffered results are ever written.
